rand_pos_gen: RTL and testbench

Consumes the serial random bit stream from the game's random bit source and turns it into a bounded random position index on request. It collects WIDTH bits, rejects out-of-range or excluded candidates, and retries up to MAX_TRIES times. If every try is rejected, it emits a deterministic fallback position. It sits between the random bit source and the game-logic FSM, for example to place a new target at a cell other than the current one.

---
 rtl/rand_pos_gen.sv | 130 +++++++++++++
 tb/tb_rand_pos_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rand_pos_gen.sv
// Bounded random position generator: draws WIDTH-bit candidates from a serial
// random bit stream, rejects out-of-range or excluded values, falls back after MAX_TRIES.
module rand_pos_gen #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned LIMIT     = 12,
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_en,
    input  logic             req,
    input  logic [WIDTH-1:0] excl,
    output logic             busy,
    output logic             pos_valid,
    output logic [WIDTH-1:0] pos,
    output logic             fallback
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned EXT_W = WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [TRY_W-1:0] try_cnt_q;
    logic [WIDTH-1:0] excl_q;
    logic [WIDTH-1:0] pos_q;
    logic             pos_valid_q;
    logic             fallback_q;
    logic             busy_q;

    logic [WIDTH-1:0] shreg_shift;
    logic             cand_ok;
    logic             last_bit;
    logic             last_try;
    logic [EXT_W-1:0] excl_ext;
    logic [EXT_W-1:0] excl_inc;
    logic [WIDTH-1:0] fb_pos;

    // Candidate evaluation and fallback value, all in WIDTH+1 bits so LIMIT == 2^WIDTH works
    always_comb begin
        shreg_shift = {shreg_q[WIDTH-2:0], bit_in};
        cand_ok     = ({1'b0, shreg_q} < EXT_W'(LIMIT)) && (shreg_q != excl_q);
        last_bit    = (bit_cnt_q == CNT_W'(WIDTH - 1));
        last_try    = (try_cnt_q == TRY_W'(MAX_TRIES - 1));
        excl_ext    = {1'b0, excl_q};
        excl_inc    = excl_ext + EXT_W'(1);
        fb_pos      = '0;
        if (excl_ext < EXT_W'(LIMIT) && excl_inc != EXT_W'(LIMIT)) begin
            fb_pos = WIDTH'(excl_inc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            try_cnt_q   <= '0;
            excl_q      <= '0;
            pos_q       <= '0;
            pos_valid_q <= 1'b0;
            fallback_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            pos_valid_q <= 1'b0;
            fallback_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        excl_q    <= excl;
                        shreg_q   <= '0;
                        bit_cnt_q <= '0;
                        try_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (bit_en) begin
                        shreg_q <= shreg_shift;
                        if (last_bit) begin
                            bit_cnt_q <= '0;
                            state_q   <= S_CHECK;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_CHECK: begin
                    if (cand_ok) begin
                        pos_q       <= shreg_q;
                        pos_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else if (last_try) begin
                        try_cnt_q   <= try_cnt_q + TRY_W'(1);
                        pos_q       <= fb_pos;
                        pos_valid_q <= 1'b1;
                        fallback_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        try_cnt_q <= try_cnt_q + TRY_W'(1);
                        shreg_q   <= '0;
                        state_q   <= S_COLLECT;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign pos_valid = pos_valid_q;
    assign pos       = pos_q;
    assign fallback  = fallback_q;

endmodule

// File: tb/tb_rand_pos_gen.sv
// Directed bench for rand_pos_gen: per-edge stimulus tables, expected values worked out by hand.
module tb_rand_pos_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_en;
    logic       req;
    logic [3:0] excl;
    logic       busy;
    logic       pos_valid;
    logic [3:0] pos;
    logic       fallback;

    int n_cmp  = 0;
    int n_fail = 0;

    // Stimulus applied before edge i, observations taken 1 ns after edge i
    logic       rst_a  [0:63];
    logic       req_a  [0:63];
    logic [3:0] excl_a [0:63];
    logic       en_a   [0:63];
    logic       bt_a   [0:63];
    logic       pv_rec [0:63];
    logic       fb_rec [0:63];
    logic       bz_rec [0:63];
    logic [3:0] pos_rec[0:63];

    rand_pos_gen #(.WIDTH(4), .LIMIT(12), .MAX_TRIES(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bit_in   (bit_in),
        .bit_en   (bit_en),
        .req      (req),
        .excl     (excl),
        .busy     (busy),
        .pos_valid(pos_valid),
        .pos      (pos),
        .fallback (fallback)
    );

    always #5 clk = ~clk;

    task automatic clr_seq(input logic [3:0] ex);
        for (int i = 0; i < 64; i++) begin
            rst_a[i]  = 1'b0;
            req_a[i]  = 1'b0;
            excl_a[i] = ex;
            en_a[i]   = 1'b0;
            bt_a[i]   = 1'b0;
        end
        req_a[0] = 1'b1;
    endtask

    // Four bits, MSB first, on consecutive edges starting at 'start'
    task automatic put_bits(input int start, input logic [3:0] v);
        for (int j = 0; j < 4; j++) begin
            en_a[start+j] = 1'b1;
            bt_a[start+j] = v[3-j];
        end
    endtask

    task automatic run_seq(input int n);
        for (int i = 0; i <= n; i++) begin
            rst    = rst_a[i];
            req    = req_a[i];
            excl   = excl_a[i];
            bit_en = en_a[i];
            bit_in = bt_a[i];
            @(posedge clk);
            #1;
            pv_rec[i]  = pos_valid;
            fb_rec[i]  = fallback;
            bz_rec[i]  = busy;
            pos_rec[i] = pos;
        end
        rst = 1'b0; req = 1'b0; bit_en = 1'b0; bit_in = 1'b0;
    endtask

    function automatic int first_pv(input int n);
        for (int i = 0; i <= n; i++) if (pv_rec[i]) return i;
        return -1;
    endfunction

    function automatic int pv_count(input int n);
        int c = 0;
        for (int i = 0; i <= n; i++) if (pv_rec[i]) c++;
        return c;
    endfunction

    task automatic test_reset();
        clr_seq(4'd15);
        for (int i = 0; i < 3; i++) begin
            rst_a[i] = 1'b1; req_a[i] = 1'b1; en_a[i] = 1'b1; bt_a[i] = 1'($urandom_range(1));
        end
        req_a[3] = 1'b1;
        put_bits(4, 4'b0000);
        run_seq(9);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({bz_rec[i], pv_rec[i], fb_rec[i], pos_rec[i]} !== 7'd0) begin
                n_fail++;
                $display("FAIL reset_outputs edge %0d: busy/pv/fb/pos got %b/%b/%b/%0d, expected 0/0/0/0",
                         i, bz_rec[i], pv_rec[i], fb_rec[i], pos_rec[i]);
            end
        end
        n_cmp++;
        if (bz_rec[3] !== 1'b1) begin
            n_fail++; $display("FAIL reset_first_req: busy got %b expected 1", bz_rec[3]);
        end
        n_cmp++;
        if (first_pv(9) !== 8 || pos_rec[8] !== 4'd0) begin
            n_fail++; $display("FAIL reset_first_draw: pv edge %0d pos %0d, expected edge 8 pos 0",
                               first_pv(9), pos_rec[8]);
        end
    endtask

    task automatic test_single_draw();
        clr_seq(4'd15);
        put_bits(1, 4'b0101);
        run_seq(7);
        n_cmp++;
        if (first_pv(7) !== 5 || pv_count(7) !== 1) begin
            n_fail++; $display("FAIL single_latency: pv edge %0d count %0d, expected edge 5 count 1",
                               first_pv(7), pv_count(7));
        end
        n_cmp++;
        if (pos_rec[5] !== 4'd5 || fb_rec[5] !== 1'b0) begin
            n_fail++; $display("FAIL single_value: pos %0d fb %b, expected 5 fb 0", pos_rec[5], fb_rec[5]);
        end
        n_cmp++;
        if (bz_rec[4] !== 1'b1 || bz_rec[5] !== 1'b0) begin
            n_fail++; $display("FAIL single_busy: busy@4 %b busy@5 %b, expected 1 and 0", bz_rec[4], bz_rec[5]);
        end
        n_cmp++;
        if (pos_rec[7] !== 4'd5) begin
            n_fail++; $display("FAIL single_hold: pos got %0d expected 5", pos_rec[7]);
        end
    endtask

    task automatic test_range_reject();
        clr_seq(4'd15);
        put_bits(1, 4'b1101);
        put_bits(6, 4'b0011);
        run_seq(11);
        n_cmp++;
        if (first_pv(11) !== 10 || pv_count(11) !== 1) begin
            n_fail++; $display("FAIL range_latency: pv edge %0d count %0d, expected edge 10 count 1",
                               first_pv(11), pv_count(11));
        end
        n_cmp++;
        if (pos_rec[10] !== 4'd3 || fb_rec[10] !== 1'b0) begin
            n_fail++; $display("FAIL range_value: pos %0d fb %b, expected 3 fb 0", pos_rec[10], fb_rec[10]);
        end
    endtask

    task automatic test_excl_stall();
        clr_seq(4'd5);
        put_bits(1, 4'b0101);
        en_a[6] = 1'b1; bt_a[6] = 1'b0;
        en_a[7] = 1'b1; bt_a[7] = 1'b1;
        en_a[11] = 1'b1; bt_a[11] = 1'b1;
        en_a[12] = 1'b1; bt_a[12] = 1'b0;
        req_a[8] = 1'b1; excl_a[8] = 4'd6;
        run_seq(14);
        n_cmp++;
        if (first_pv(14) !== 13 || pv_count(14) !== 1) begin
            n_fail++; $display("FAIL excl_stall_latency: pv edge %0d count %0d, expected edge 13 count 1",
                               first_pv(14), pv_count(14));
        end
        n_cmp++;
        if (pos_rec[13] !== 4'd6 || fb_rec[13] !== 1'b0) begin
            n_fail++; $display("FAIL excl_stall_value: pos %0d fb %b, expected 6 fb 0", pos_rec[13], fb_rec[13]);
        end
    endtask

    task automatic test_fallback();
        logic [3:0] ex_v [0:1];
        logic [3:0] exp_v[0:1];
        ex_v[0] = 4'd11; exp_v[0] = 4'd0;
        ex_v[1] = 4'd3;  exp_v[1] = 4'd4;
        for (int t = 0; t < 2; t++) begin
            clr_seq(ex_v[t]);
            for (int i = 1; i <= 41; i++) begin en_a[i] = 1'b1; bt_a[i] = 1'b1; end
            run_seq(42);
            n_cmp++;
            if (first_pv(42) !== 40 || pv_count(42) !== 1) begin
                n_fail++; $display("FAIL fallback_latency excl=%0d: pv edge %0d count %0d, expected edge 40 count 1",
                                   ex_v[t], first_pv(42), pv_count(42));
            end
            n_cmp++;
            if (pos_rec[40] !== exp_v[t] || fb_rec[40] !== 1'b1 || fb_rec[41] !== 1'b0) begin
                n_fail++; $display("FAIL fallback_value excl=%0d: pos %0d fb %b/%b, expected %0d fb 1/0",
                                   ex_v[t], pos_rec[40], fb_rec[40], fb_rec[41], exp_v[t]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clr_seq(4'd15);
        put_bits(1, 4'b1000);
        req_a[6] = 1'b1; excl_a[6] = 4'd8;
        put_bits(7, 4'b1000);
        put_bits(12, 4'b0010);
        run_seq(17);
        n_cmp++;
        if (pos_rec[5] !== 4'd8 || pv_rec[5] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first: pos %0d pv %b, expected 8 pv 1", pos_rec[5], pv_rec[5]);
        end
        n_cmp++;
        if (bz_rec[6] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_accept: busy got %b expected 1", bz_rec[6]);
        end
        n_cmp++;
        if (pv_count(17) !== 2 || pv_rec[16] !== 1'b1 || pos_rec[16] !== 4'd2) begin
            n_fail++; $display("FAIL b2b_second: pv count %0d pv@16 %b pos %0d, expected 2/1/2",
                               pv_count(17), pv_rec[16], pos_rec[16]);
        end
    endtask

    task automatic test_reset_mid();
        clr_seq(4'd15);
        put_bits(1, 4'b1111);
        rst_a[2] = 1'b1;
        run_seq(8);
        n_cmp++;
        if (bz_rec[1] !== 1'b1 || bz_rec[2] !== 1'b0 || pos_rec[2] !== 4'd0) begin
            n_fail++; $display("FAIL mid_reset_state: busy %b/%b pos %0d, expected 1/0 pos 0",
                               bz_rec[1], bz_rec[2], pos_rec[2]);
        end
        n_cmp++;
        if (pv_count(8) !== 0) begin
            n_fail++; $display("FAIL mid_reset_no_pv: pv count %0d expected 0", pv_count(8));
        end
        clr_seq(4'd15);
        put_bits(1, 4'b0010);
        run_seq(6);
        n_cmp++;
        if (first_pv(6) !== 5 || pos_rec[5] !== 4'd2) begin
            n_fail++; $display("FAIL mid_reset_new_req: pv edge %0d pos %0d, expected edge 5 pos 2",
                               first_pv(6), pos_rec[5]);
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; excl = '0; bit_en = 1'b0; bit_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_draw();
        test_range_reject();
        test_excl_stall();
        test_fallback();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
